// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the execute-stage ALU / multiply-divide unit:
// op encodings, op-group decode helpers and the controller state type.
package alu_mdu_pkg;

    localparam logic [4:0] ALU_OP_ADD    = 5'd0;
    localparam logic [4:0] ALU_OP_SUB    = 5'd1;
    localparam logic [4:0] ALU_OP_AND    = 5'd2;
    localparam logic [4:0] ALU_OP_OR     = 5'd3;
    localparam logic [4:0] ALU_OP_XOR    = 5'd4;
    localparam logic [4:0] ALU_OP_SLL    = 5'd5;
    localparam logic [4:0] ALU_OP_SRL    = 5'd6;
    localparam logic [4:0] ALU_OP_SRA    = 5'd7;
    localparam logic [4:0] ALU_OP_SLT    = 5'd8;
    localparam logic [4:0] ALU_OP_SLTU   = 5'd9;
    localparam logic [4:0] ALU_OP_BEQ    = 5'd10;
    localparam logic [4:0] ALU_OP_BNE    = 5'd11;
    localparam logic [4:0] ALU_OP_BLT    = 5'd12;
    localparam logic [4:0] ALU_OP_BGE    = 5'd13;
    localparam logic [4:0] ALU_OP_BLTU   = 5'd14;
    localparam logic [4:0] ALU_OP_BGEU   = 5'd15;
    localparam logic [4:0] ALU_OP_MUL    = 5'd16;
    localparam logic [4:0] ALU_OP_MULH   = 5'd17;
    localparam logic [4:0] ALU_OP_MULHSU = 5'd18;
    localparam logic [4:0] ALU_OP_MULHU  = 5'd19;
    localparam logic [4:0] ALU_OP_DIV    = 5'd20;
    localparam logic [4:0] ALU_OP_DIVU   = 5'd21;
    localparam logic [4:0] ALU_OP_REM    = 5'd22;
    localparam logic [4:0] ALU_OP_REMU   = 5'd23;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EXEC  = 3'd1,
        ST_ITER  = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic is_iter(input logic [4:0] op);
        return (op >= ALU_OP_MUL) && (op <= ALU_OP_REMU);
    endfunction

    function automatic logic is_cmp(input logic [4:0] op);
        return (op >= ALU_OP_BEQ) && (op <= ALU_OP_BGEU);
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return (op >= ALU_OP_DIV) && (op <= ALU_OP_REMU);
    endfunction

    function automatic logic is_signed_div(input logic [4:0] op);
        return (op == ALU_OP_DIV) || (op == ALU_OP_REM);
    endfunction

    // MUL low half is sign-agnostic, so treating it as signed is harmless
    function automatic logic a_is_signed(input logic [4:0] op);
        return (op == ALU_OP_MUL) || (op == ALU_OP_MULH) || (op == ALU_OP_MULHSU) ||
               is_signed_div(op);
    endfunction

    function automatic logic b_is_signed(input logic [4:0] op);
        return (op == ALU_OP_MUL) || (op == ALU_OP_MULH) || is_signed_div(op);
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Operation/result handshake bundle between operand select, the ALU/MDU and writeback.
interface alu_mdu_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag;
    logic             busy;

    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, result, flag, busy
    );

    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, result, flag, busy
    );
endinterface

// File: rtl/alu_mdu_iter.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide, one bit per cycle.
// hi/lo end up as the 2*WIDTH product, or remainder/quotient for a divide.
module alu_mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             kill_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_mag_i,
    input  logic [WIDTH-1:0] b_mag_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d, div_q;
    logic [WIDTH:0]   sum, shl, diff;

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        cnt_d = cnt_q;
        run_d = run_q;
        sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shl   = {hi_q, lo_q[WIDTH-1]};
        diff  = shl - {1'b0, b_q};
        if (kill_i) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (start_i) begin
            hi_d  = '0;
            lo_d  = a_mag_i;
            cnt_d = CW'(WIDTH - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            if (div_q) begin
                // diff MSB set means the trial subtraction borrowed: restore
                if (!diff[WIDTH]) begin
                    hi_d = diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = shl[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
            end
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            div_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
            if (start_i && !kill_i) begin
                b_q   <= b_mag_i;
                div_q <= div_i;
            end
        end
    end

    assign done_o = run_q && (cnt_q == '0);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with branch compare and iterative M-extension unit behind a
// valid/ready handshake; one operation in flight, flush aborts it.
//
//   state    | meaning
//   ST_IDLE  | waiting for an operation, in_ready=1
//   ST_EXEC  | single-cycle, compare or divide special case being evaluated
//   ST_ITER  | iterative multiply/divide running, WIDTH cycles
//   ST_FIXUP | sign correction and half select on the iterative result
//   ST_DONE  | result presented, waiting for out_ready
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst_n,
    alu_mdu_if.slave  bus
);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [4:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, result_q, result_d;
    logic             flag_q, flag_d;

    logic             accept, go_iter, iter_done;
    logic [WIDTH-1:0] a_mag, b_mag, iter_hi, iter_lo;
    logic [WIDTH-1:0] exec_res, fix_res;
    logic             exec_flag;

    function automatic logic is_special(input logic [4:0] op, input logic [WIDTH-1:0] x,
                                        input logic [WIDTH-1:0] y);
        return (is_div(op) && (y == '0)) ||
               (is_signed_div(op) && (x == MOST_NEG) && (y == '1));
    endfunction

    assign accept  = bus.in_valid && bus.in_ready && !bus.flush;
    assign go_iter = is_iter(bus.op) && !is_special(bus.op, bus.a, bus.b);
    assign a_mag   = (a_is_signed(bus.op) && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag   = (b_is_signed(bus.op) && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (accept && go_iter),
        .kill_i  (bus.flush),
        .div_i   (is_div(bus.op)),
        .a_mag_i (a_mag),
        .b_mag_i (b_mag),
        .done_o  (iter_done),
        .hi_o    (iter_hi),
        .lo_o    (iter_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = go_iter ? ST_ITER : ST_EXEC;
            ST_EXEC:  state_d = ST_DONE;
            ST_ITER:  if (iter_done) state_d = ST_FIXUP;
            ST_FIXUP: state_d = ST_DONE;
            ST_DONE: begin
                if (accept)             state_d = go_iter ? ST_ITER : ST_EXEC;
                else if (bus.out_ready) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
        if (bus.flush) state_d = ST_IDLE;
    end

    always_comb begin
        logic [WIDTH-1:0] diff;
        logic [SHW-1:0]   sh;
        diff      = a_q - b_q;
        sh        = b_q[SHW-1:0];
        exec_res  = '0;
        exec_flag = 1'b0;
        case (op_q)
            ALU_OP_ADD:  exec_res = a_q + b_q;
            ALU_OP_SUB:  exec_res = diff;
            ALU_OP_AND:  exec_res = a_q & b_q;
            ALU_OP_OR:   exec_res = a_q | b_q;
            ALU_OP_XOR:  exec_res = a_q ^ b_q;
            ALU_OP_SLL:  exec_res = a_q << sh;
            ALU_OP_SRL:  exec_res = a_q >> sh;
            ALU_OP_SRA:  exec_res = $signed(a_q) >>> sh;
            ALU_OP_SLT:  exec_res = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            ALU_OP_SLTU: exec_res = {{(WIDTH-1){1'b0}}, a_q < b_q};
            ALU_OP_BEQ:  begin exec_res = diff; exec_flag = (a_q == b_q); end
            ALU_OP_BNE:  begin exec_res = diff; exec_flag = (a_q != b_q); end
            ALU_OP_BLT:  begin exec_res = diff; exec_flag = ($signed(a_q) <  $signed(b_q)); end
            ALU_OP_BGE:  begin exec_res = diff; exec_flag = ($signed(a_q) >= $signed(b_q)); end
            ALU_OP_BLTU: begin exec_res = diff; exec_flag = (a_q <  b_q); end
            ALU_OP_BGEU: begin exec_res = diff; exec_flag = (a_q >= b_q); end
            // Divides only reach EXEC as zero-divisor or signed-overflow cases
            ALU_OP_DIV, ALU_OP_DIVU: exec_res = (b_q == '0) ? '1 : a_q;
            ALU_OP_REM, ALU_OP_REMU: exec_res = (b_q == '0) ? a_q : '0;
            default:     exec_res = '0;
        endcase
    end

    always_comb begin
        logic             a_neg, b_neg;
        logic [2*WIDTH-1:0] prod;
        a_neg   = a_is_signed(op_q) && a_q[WIDTH-1];
        b_neg   = b_is_signed(op_q) && b_q[WIDTH-1];
        prod    = (a_neg ^ b_neg) ? -{iter_hi, iter_lo} : {iter_hi, iter_lo};
        fix_res = '0;
        case (op_q)
            ALU_OP_MUL:                  fix_res = prod[WIDTH-1:0];
            ALU_OP_MULH, ALU_OP_MULHSU,
            ALU_OP_MULHU:                fix_res = prod[2*WIDTH-1:WIDTH];
            ALU_OP_DIV, ALU_OP_DIVU:     fix_res = (a_neg ^ b_neg) ? -iter_lo : iter_lo;
            ALU_OP_REM, ALU_OP_REMU:     fix_res = a_neg ? -iter_hi : iter_hi;
            default:                     fix_res = '0;
        endcase
    end

    always_comb begin
        result_d = result_q;
        flag_d   = flag_q;
        if (bus.flush) begin
            flag_d = 1'b0;
        end else if (state_q == ST_EXEC) begin
            result_d = exec_res;
            flag_d   = exec_flag;
        end else if (state_q == ST_FIXUP) begin
            result_d = fix_res;
            flag_d   = 1'b0;
        end
        bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
        bus.out_valid = (state_q == ST_DONE);
        bus.busy      = (state_q != ST_IDLE);
        bus.result    = result_q;
        bus.flag      = flag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= bus.op;
                a_q  <= bus.a;
                b_q  <= bus.b;
            end
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised successor to the single-cycle ALU. Adds WIDTH generalisation, a registered valid/ready handshake, a branch-compare flag with all six RISC-V conditions, and an iterative multiply/divide unit for the M-extension. It sits in the execute stage between operand select and writeback. A single operation is in flight at a time; flush kills it.

## Interface
Parameters:
- WIDTH, 32, operand/result width; power of two, ≥8
- SHW, $clog2(WIDTH), shift-amount bits taken from B

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid & in_ready
- op  in  5  operation code (alu_pkg)
- a, b  in  WIDTH  operands
- flush  in  1  abort in-flight op, return to IDLE
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  registered result
- flag  out  1  registered branch-compare outcome (0 for non-compare ops)
- busy  out  1  state != IDLE

## Operation
- Single-cycle group: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA (arithmetic, b[SHW-1:0]), SLT, SLTU (result 1/0).
- Compare group: BEQ, BNE, BLT, BGE, BLTU, BGEU. Result = a-b; flag = condition, signed or unsigned as named.
- Iterative group: MUL, MULH, MULHSU, MULHU (shift-add on 2·WIDTH product; low or high half selected), DIV, DIVU, REM, REMU (restoring, one quotient bit per cycle; signs fixed up at end).
- Special cases resolve in one cycle with no iteration:
  - divide by zero: quotient all-ones, remainder a
  - signed overflow (a = most-negative, b = -1): quotient a, remainder 0
- Undefined op code: result 0, flag 0, single-cycle.
- FSM states:
  - IDLE -> EXEC on accept, for the single-cycle group, compare group and special cases
  - IDLE -> ITER on accept, iterative group
  - EXEC -> DONE
  - ITER -> ITER for WIDTH cycles, counter WIDTH-1 down to 0; -> FIXUP at count 0
  - FIXUP -> DONE (sign correction, half select)
  - DONE -> IDLE on out_ready; DONE -> EXEC/ITER directly if out_ready & in_valid
- Operands and op are latched at accept; later input changes are ignored.

## Timing
- Reset values:
  - state IDLE, so in_ready=1 and busy=0
  - out_valid=0, result=0, flag=0, counter=0
- in_ready = (state==IDLE) | (state==DONE & out_ready); combinational from state and out_ready only, never from in_valid.
- Latency from accept edge to out_valid high:
  - single-cycle, compare, special cases: 2 cycles
  - iterative ops: WIDTH+2 cycles (34 at WIDTH=32)
- result and flag hold stable while out_valid=1 & out_ready=0.
- flush has priority over every transition: next state IDLE, out_valid=0, flag=0, result unchanged. An in_valid in the flush cycle is not accepted.
- Reset mid-ITER: immediate abort to the reset values; no partial result is ever presented.
- Back-to-back: with out_ready held high and in_valid high, one single-cycle op completes every 2 cycles.

## Structure
- alu_pkg holds:
  - op encodings (`ALU_OP_*` as 5-bit localparams)
  - op-group decode functions: is_iter, is_cmp, is_signed_div
  - FSM state enum
- Sub-module mdu_iter: iterative shift-add/restoring datapath, WIDTH-parametrised.
  - Inputs: start, operands with signs stripped, mode
  - Outputs: done, hi and lo registers
- alu_mdu owns the FSM, the handshake, the single-cycle datapath, the special-case detect and the sign fix-up.

## Test plan
- All cases at WIDTH=32 unless noted.
- ADD 0x7FFFFFFF+1, out_ready=1 -> out_valid 2 cycles after accept, result 0x80000000, flag 0. SRA 0x80000000 by 4 -> 0xF8000000.
- BLT a=-1, b=1 -> flag 1; BLTU with the same operands -> flag 0; BEQ 5,5 -> flag 1, result 0.
- MULH 0x80000000×0x80000000 -> 0x40000000 after 34 cycles; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; in_ready=0 throughout.
- DIV -7/2 -> -3, REM -7/2 -> -1. DIVU 5/0 -> 0xFFFFFFFF in 2 cycles. DIV 0x80000000/-1 -> 0x80000000, REM of the same -> 0.
- Backpressure and flush:
  - hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0
  - flush at iteration 10 of a DIV -> IDLE next cycle, out_valid never asserted, next ADD correct
- rst_n low at iteration 10 of a MUL -> outputs at reset values asynchronously. Repeat the ADD and MUL checks at WIDTH=8: MUL 0x80×0x80 lo -> 0x00, latency 10.
